// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the unified-memory port arbiter:
//                FSM state encoding, requester identifiers and limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Requester identifiers; also the bit index into the request vector
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Largest read latency the 4-bit wait counter can express
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Two-input round-robin picker. Purely combinational; the
//                caller owns the last_winner register.
//  Ports       : req[1:0]     - request vector, indexed by REQ_FETCH/REQ_DATA
//                last_winner  - requester that won the previous arbitration
//                winner       - requester chosen now (valid when |req)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner
);

    always_comb begin
        winner = last_winner;
        if (req[REQ_FETCH] && req[REQ_DATA]) begin
            // Conflict: hand the port to whoever did not win last time
            winner = ~last_winner;
        end else if (req[REQ_DATA]) begin
            winner = REQ_DATA;
        end else if (req[REQ_FETCH]) begin
            winner = REQ_FETCH;
        end
    end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single-port unified memory between the
//                instruction-fetch requester and the load/store requester.
//                Serialises accesses, drives the memory address/write lines,
//                counts the fixed read latency and returns read data to the
//                owning requester. All outputs are registered.
//  Ports       : clk, rst                    - clock, async active-high reset
//                if_req/if_addr              - fetch request (held until gnt)
//                if_gnt/if_rvalid/if_rdata   - fetch grant, data-valid, data
//                d_req/d_we/d_addr/d_wdata   - load/store request
//                d_gnt/d_rvalid/d_rdata      - data grant, load-valid, data
//                mem_addr/mem_wdata/mem_we   - memory command
//                mem_rdata                   - memory read data
//                busy                        - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Out-of-range latencies are clamped into what the counter can hold
    localparam int               c_lat      = (RD_LAT < 1) ? 1 :
                                              ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(c_lat - 1);

    state_t           r_state;
    // last_winner doubles as the owner of the access in flight: it is
    // updated on entry to ISSUE and not touched again until the next ISSUE.
    logic             r_last_winner;
    logic             r_is_store;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_arb_req;
    logic             w_winner;
    logic             w_can_issue;
    logic             w_start;

    // While a store sits in ISSUE its own req is still high (it drops the
    // cycle after gnt), so only the other requester may chain in directly.
    always_comb begin
        w_arb_req = {d_req, if_req};
        if (r_state == S_ISSUE) begin
            w_arb_req[r_last_winner] = 1'b0;
        end
    end

    arb_rr2 u_arb (
        .req         (w_arb_req),
        .last_winner (r_last_winner),
        .winner      (w_winner)
    );

    assign w_can_issue = (r_state == S_IDLE) || (r_state == S_RESP) ||
                         ((r_state == S_ISSUE) && r_is_store);
    assign w_start     = w_can_issue && (|w_arb_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_winner <= REQ_FETCH;
            r_is_store    <= 1'b0;
            r_cnt         <= '0;
            if_gnt        <= 1'b0;
            if_rvalid     <= 1'b0;
            if_rdata      <= '0;
            d_gnt         <= 1'b0;
            d_rvalid      <= 1'b0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Single-cycle pulses
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_we    <= 1'b0;

            case (r_state)
                S_ISSUE: begin
                    if (r_is_store) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_cnt_init;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        if (r_last_winner == REQ_DATA) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            // A new access overrides the fall-back to IDLE chosen above
            if (w_start) begin
                r_state       <= S_ISSUE;
                busy          <= 1'b1;
                r_last_winner <= w_winner;
                if (w_winner == REQ_DATA) begin
                    d_gnt      <= 1'b1;
                    mem_addr   <= d_addr;
                    mem_wdata  <= d_wdata;
                    mem_we     <= d_we;
                    r_is_store <= d_we;
                end else begin
                    if_gnt     <= 1'b1;
                    mem_addr   <= if_addr;
                    r_is_store <= 1'b0;
                end
            end
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire
